// File: rtl/tanque_nivel_sim.sv
// Cycle-based irrigation tank model: integrates fill/drain flows into a volume,
// drives the Nv level sensors and flags overflow / dry-run abuse.
module tanque_nivel_sim #(
  parameter int unsigned VOL_W     = 8,
  parameter int unsigned VOL_MAX   = 200,
  parameter int unsigned TH0       = 20,
  parameter int unsigned TH1       = 100,
  parameter int unsigned TH2       = 180,
  parameter int unsigned FILL_DIV  = 4,
  parameter int unsigned DRAIN_DIV = 8,
  parameter int unsigned FLUSH_DIV = 2,
  parameter int unsigned INIT_VOL  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ve,
  input  logic             Limp,
  input  logic             Asp,
  output logic             Nv0,
  output logic             Nv1,
  output logic             Nv2,
  output logic [VOL_W-1:0] Vol,
  output logic             Transb,
  output logic             Seco,
  output logic [1:0]       Estado
);

  localparam int unsigned FILL_W = (FILL_DIV > 1) ? $clog2(FILL_DIV) : 1;
  localparam int unsigned DMAX   = (DRAIN_DIV > FLUSH_DIV) ? DRAIN_DIV : FLUSH_DIV;
  localparam int unsigned DRN_W  = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam logic [2:0]  NV_INIT = {INIT_VOL >= TH2, INIT_VOL >= TH1, INIT_VOL >= TH0};

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_ASP  = 2'b01,
    SRC_LIMP = 2'b10
  } src_e;

  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
  src_e              src_q, src_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [2:0]        nv_q, nv_d;
  logic              transb_q, transb_d;
  logic              seco_q, seco_d;
  logic [1:0]        estado_q, estado_d;

  logic              fill_tick_c;
  logic              drain_tick_c;
  logic              src_change_c;
  logic [DRN_W-1:0]  drain_last_c;

  // Prescalers, volume integration and sticky abuse flags.
  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    src_d        = src_q;
    vol_d        = vol_q;
    nv_d         = nv_q;
    transb_d     = transb_q;
    seco_d       = seco_q;
    estado_d     = estado_q;
    fill_tick_c  = 1'b0;
    drain_tick_c = 1'b0;
    src_change_c = 1'b0;
    drain_last_c = DRN_W'(DRAIN_DIV - 1);

    src_d = Limp ? SRC_LIMP : (Asp ? SRC_ASP : SRC_NONE);
    if (src_d == SRC_LIMP) drain_last_c = DRN_W'(FLUSH_DIV - 1);
    // Only an Asp<->Limp swap restarts the count; starting from idle is already at 0.
    src_change_c = (src_d != SRC_NONE) && (src_q != SRC_NONE) && (src_d != src_q);

    fill_tick_c  = Ve && (fill_cnt_q == FILL_W'(FILL_DIV - 1));
    drain_tick_c = (src_d != SRC_NONE) && !src_change_c && (drain_cnt_q == drain_last_c);

    fill_cnt_d  = (!Ve || fill_tick_c) ? '0 : fill_cnt_q + FILL_W'(1);
    drain_cnt_d = ((src_d == SRC_NONE) || src_change_c || drain_tick_c)
                  ? '0 : drain_cnt_q + DRN_W'(1);

    if (fill_tick_c && !drain_tick_c) begin
      if (vol_q == VOL_W'(VOL_MAX)) transb_d = 1'b1;
      else                          vol_d    = vol_q + VOL_W'(1);
    end else if (drain_tick_c && !fill_tick_c) begin
      if (vol_q == '0) seco_d = 1'b1;
      else             vol_d  = vol_q - VOL_W'(1);
    end

    nv_d     = {vol_d >= VOL_W'(TH2), vol_d >= VOL_W'(TH1), vol_d >= VOL_W'(TH0)};
    estado_d = {src_d != SRC_NONE, Ve};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      src_q       <= SRC_NONE;
      vol_q       <= VOL_W'(INIT_VOL);
      nv_q        <= NV_INIT;
      transb_q    <= 1'b0;
      seco_q      <= 1'b0;
      estado_q    <= 2'b00;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      src_q       <= src_d;
      vol_q       <= vol_d;
      nv_q        <= nv_d;
      transb_q    <= transb_d;
      seco_q      <= seco_d;
      estado_q    <= estado_d;
    end
  end

  assign Nv0    = nv_q[0];
  assign Nv1    = nv_q[1];
  assign Nv2    = nv_q[2];
  assign Vol    = vol_q;
  assign Transb = transb_q;
  assign Seco   = seco_q;
  assign Estado = estado_q;

endmodule

// File: tb/tb_tanque_nivel_sim.sv
// Scoreboard bench for tanque_nivel_sim: a behavioural tank model predicts every
// cycle's outputs, plus directed checkpoints taken from the tank's intended timing.
module tb_tanque_nivel_sim;

  localparam int unsigned VOL_W     = 8;
  localparam int unsigned VOL_MAX   = 200;
  localparam int unsigned TH0       = 20;
  localparam int unsigned TH1       = 100;
  localparam int unsigned TH2       = 180;
  localparam int unsigned FILL_DIV  = 4;
  localparam int unsigned DRAIN_DIV = 8;
  localparam int unsigned FLUSH_DIV = 2;
  localparam int unsigned INIT_VOL  = 0;

  logic             clk = 1'b0;
  logic             reset, Ve, Limp, Asp;
  logic             Nv0, Nv1, Nv2;
  logic [VOL_W-1:0] Vol;
  logic             Transb, Seco;
  logic [1:0]       Estado;

  always #5 clk = ~clk;

  tanque_nivel_sim #(
    .VOL_W(VOL_W), .VOL_MAX(VOL_MAX), .TH0(TH0), .TH1(TH1), .TH2(TH2),
    .FILL_DIV(FILL_DIV), .DRAIN_DIV(DRAIN_DIV), .FLUSH_DIV(FLUSH_DIV),
    .INIT_VOL(INIT_VOL)
  ) dut (
    .clk(clk), .reset(reset), .Ve(Ve), .Limp(Limp), .Asp(Asp),
    .Nv0(Nv0), .Nv1(Nv1), .Nv2(Nv2), .Vol(Vol),
    .Transb(Transb), .Seco(Seco), .Estado(Estado)
  );

  typedef struct packed {
    logic [VOL_W-1:0] vol;
    logic [2:0]       nv;
    logic             tr;
    logic             se;
    logic [1:0]       est;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // Tank model state
  int   m_vol, m_fc, m_dc, m_src;
  bit   m_tr, m_se;
  logic [1:0] m_est;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_step(input bit ve, input bit limp, input bit asp, input bit rst);
    int  src, div;
    bit  ft, dt, sw;
    if (rst) begin
      m_vol = INIT_VOL; m_fc = 0; m_dc = 0; m_src = 0;
      m_tr = 0; m_se = 0; m_est = 2'b00;
      return;
    end
    src = limp ? 2 : (asp ? 1 : 0);
    div = (src == 2) ? FLUSH_DIV : DRAIN_DIV;
    sw  = (src != 0) && (m_src != 0) && (src != m_src);
    ft  = ve && (m_fc == FILL_DIV - 1);
    dt  = (src != 0) && !sw && (m_dc == div - 1);
    if (ft && !dt) begin
      if (m_vol == VOL_MAX) m_tr = 1;
      else                  m_vol = m_vol + 1;
    end else if (dt && !ft) begin
      if (m_vol == 0) m_se = 1;
      else            m_vol = m_vol - 1;
    end
    m_fc  = ve ? (m_fc + 1) % FILL_DIV : 0;
    m_dc  = (src == 0 || sw) ? 0 : (m_dc + 1) % div;
    m_src = src;
    m_est = {src != 0, ve};
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.vol = VOL_W'(m_vol);
    o.nv  = {m_vol >= TH2, m_vol >= TH1, m_vol >= TH0};
    o.tr  = m_tr;
    o.se  = m_se;
    o.est = m_est;
    return o;
  endfunction

  // Drive one cycle, queue the prediction, then compare after the edge.
  task automatic step(input bit ve, input bit limp, input bit asp, input bit rst);
    obs_t e, o;
    reset = rst; Ve = ve; Limp = limp; Asp = asp;
    model_step(ve, limp, asp, rst);
    exp_q.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    o = {Vol, Nv2, Nv1, Nv0, Transb, Seco, Estado};
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      chk("sb", 32'(o), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1; Ve = 1'b0; Limp = 1'b0; Asp = 1'b0;
    m_vol = 0; m_fc = 0; m_dc = 0; m_src = 0; m_tr = 0; m_se = 0; m_est = 2'b00;
    @(negedge clk);

    step(0, 0, 0, 1);
    chk("rst_vol", 32'(Vol), 32'd0);
    chk("rst_nv", 32'({Nv2, Nv1, Nv0}), 32'd0);
    chk("rst_flags", 32'({Transb, Seco}), 32'd0);
    chk("rst_estado", 32'(Estado), 32'd0);

    // Fill from empty to overflow
    for (int i = 1; i <= 810; i++) begin
      step(1, 0, 0, 0);
      if (i == 1)   chk("fill_estado", 32'(Estado), 32'd1);
      if (i == 3)   chk("fill_vol3", 32'(Vol), 32'd0);
      if (i == 4)   chk("fill_vol4", 32'(Vol), 32'd1);
      if (i == 79)  chk("fill_nv79", 32'({Nv2, Nv1, Nv0}), 32'b000);
      if (i == 80)  chk("fill_nv80", 32'({Nv2, Nv1, Nv0}), 32'b001);
      if (i == 400) chk("fill_nv400", 32'({Nv2, Nv1, Nv0}), 32'b011);
      if (i == 720) chk("fill_nv720", 32'({Nv2, Nv1, Nv0}), 32'b111);
      if (i == 800) chk("fill_vol800", 32'(Vol), 32'd200);
      if (i == 803) chk("fill_tr803", 32'(Transb), 32'd0);
      if (i == 804) chk("fill_tr804", 32'(Transb), 32'd1);
      if (i == 810) chk("fill_hold", 32'(Vol), 32'd200);
    end

    // Flush to dry
    for (int i = 1; i <= 410; i++) begin
      step(0, 1, 0, 0);
      if (i == 1)   chk("flush_estado", 32'(Estado), 32'd2);
      if (i == 41)  chk("flush_nv2_41", 32'(Nv2), 32'd1);
      if (i == 42)  chk("flush_vol42", 32'(Vol), 32'd179);
      if (i == 42)  chk("flush_nv2_42", 32'(Nv2), 32'd0);
      if (i == 400) chk("flush_vol400", 32'(Vol), 32'd0);
      if (i == 401) chk("flush_seco401", 32'(Seco), 32'd0);
      if (i == 402) chk("flush_seco402", 32'(Seco), 32'd1);
    end

    // Mixed fill + sprinkler from vol=100
    step(0, 0, 0, 1);
    for (int i = 1; i <= 400; i++) step(1, 0, 0, 0);
    chk("mix_start", 32'(Vol), 32'd100);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 1, 0);
      if (i == 1)  chk("mix_estado", 32'(Estado), 32'd3);
      if (i == 8)  chk("mix_vol8", 32'(Vol), 32'd101);
      if (i == 16) chk("mix_vol16", 32'(Vol), 32'd102);
    end
    chk("mix_flags", 32'({Transb, Seco}), 32'd0);

    // Sprinkler partial count discarded on switch to flush
    step(0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 0);
    chk("sw_asp", 32'(Vol), 32'd102);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0);
      if (i == 2) chk("sw_flush2", 32'(Vol), 32'd102);
      if (i == 3) chk("sw_flush3", 32'(Vol), 32'd101);
    end

    // Reset mid-fill
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("mrst_vol", 32'(Vol), 32'(INIT_VOL));
    chk("mrst_flags", 32'({Transb, Seco}), 32'd0);
    chk("mrst_estado", 32'(Estado), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      if (i == 3) chk("mrst_vol3", 32'(Vol), 32'd0);
      if (i == 4) chk("mrst_vol4", 32'(Vol), 32'd1);
    end

    // Ve toggled faster than the fill prescaler never ticks
    step(0, 0, 0, 1);
    for (int i = 0; i < 60; i++) step(((i / 3) % 2) == 0, 0, 0, 0);
    chk("tog_vol", 32'(Vol), 32'd0);
    chk("tog_nv", 32'({Nv2, Nv1, Nv0}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
